frame_sequencer: RTL and testbench

Frame-level controller for the acquisition output path. It sequences the 4-word header generator, then a fixed-length payload read from the sample FIFO, into the Xillybus upstream FIFO. It owns the frame and PPS counters that the header generator embeds. It sits between the sample FIFO, the header generator and the host-facing write FIFO.

---
 rtl/frame_sequencer.sv | 134 +++++++++++++
 tb/tb_frame_sequencer.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: emits a fixed-length header from the header generator, then a fixed-length
// payload from the sample FIFO, into the upstream FIFO. Owns the frame and PPS counters.
module frame_sequencer #(
    parameter int unsigned PAYLOAD_WORDS = 256,
    parameter int unsigned HDR_WORDS     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pps_in,
    output logic        hdr_rd_en,
    input  logic [31:0] hdr_data,
    output logic [31:0] frame_count,
    output logic [31:0] pps_count,
    input  logic        pay_empty,
    output logic        pay_rd_en,
    input  logic [31:0] pay_data,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam logic [2:0]  HdrLast = 3'(HDR_WORDS - 1);
    localparam logic [15:0] PayLast = 16'(PAYLOAD_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;

    state_e      state_q, state_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] pay_idx_q, pay_idx_d;
    logic [31:0] frame_count_q, frame_count_d;
    logic [31:0] pps_count_q, pps_count_d;
    logic [31:0] pps_live_q;
    logic        pps_meta_q, pps_sync_q, pps_prev_q;
    logic        pps_edge;

    assign frame_count = frame_count_q;
    assign pps_count   = pps_count_q;

    // Two-flop synchronizer plus one flop for edge detection: 3 clk from pps_in to pps_live.
    assign pps_edge = pps_sync_q & ~pps_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pps_meta_q <= 1'b0;
            pps_sync_q <= 1'b0;
            pps_prev_q <= 1'b0;
            pps_live_q <= '0;
        end else begin
            pps_meta_q <= pps_in;
            pps_sync_q <= pps_meta_q;
            pps_prev_q <= pps_sync_q;
            if (pps_edge) begin
                pps_live_q <= pps_live_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            hdr_idx_q     <= '0;
            pay_idx_q     <= '0;
            frame_count_q <= '0;
            pps_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            hdr_idx_q     <= hdr_idx_d;
            pay_idx_q     <= pay_idx_d;
            frame_count_q <= frame_count_d;
            pps_count_q   <= pps_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hdr_idx_d     = hdr_idx_q;
        pay_idx_d     = pay_idx_q;
        frame_count_d = frame_count_q;
        pps_count_d   = pps_count_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    pps_count_d = pps_live_q;
                    hdr_idx_d   = '0;
                    pay_idx_d   = '0;
                    state_d     = StHdr;
                end
            end
            StHdr: begin
                if (hdr_rd_en) begin
                    hdr_idx_d = hdr_idx_q + 3'd1;
                    if (hdr_idx_q == HdrLast) begin
                        state_d = StPay;
                    end
                end
            end
            StPay: begin
                if (pay_rd_en) begin
                    pay_idx_d = pay_idx_q + 16'd1;
                    if (pay_idx_q == PayLast) begin
                        frame_count_d = frame_count_q + 32'd1;
                        state_d       = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes are combinational on the current flags so a freed slot is used the same cycle.
    always_comb begin
        hdr_rd_en = 1'b0;
        pay_rd_en = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        unique case (state_q)
            StHdr: begin
                busy      = 1'b1;
                out_data  = hdr_data;
                hdr_rd_en = ~out_full;
            end
            StPay: begin
                busy      = 1'b1;
                out_data  = pay_data;
                pay_rd_en = ~pay_empty & ~out_full;
            end
            default: ;
        endcase
        out_wr_en = hdr_rd_en | pay_rd_en;
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a 4-word header generator model and a sample FIFO model.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pps_in = 1'b0;
    logic        hdr_rd_en;
    logic [31:0] hdr_data;
    logic [31:0] frame_count;
    logic [31:0] pps_count;
    logic        pay_empty;
    logic        pay_rd_en;
    logic [31:0] pay_data;
    logic        out_full = 1'b0;
    logic        out_wr_en;
    logic [31:0] out_data;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    frame_sequencer #(
        .PAYLOAD_WORDS(8),
        .HDR_WORDS    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pps_in     (pps_in),
        .hdr_rd_en  (hdr_rd_en),
        .hdr_data   (hdr_data),
        .frame_count(frame_count),
        .pps_count  (pps_count),
        .pay_empty  (pay_empty),
        .pay_rd_en  (pay_rd_en),
        .pay_data   (pay_data),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Header generator model: words fc, pps, fc^pps, fc+pps.
    logic [1:0] gen_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) gen_idx <= 2'd0;
        else if (hdr_rd_en) gen_idx <= gen_idx + 2'd1;
    end
    always_comb begin
        hdr_data = 32'd0;
        case (gen_idx)
            2'd0:    hdr_data = frame_count;
            2'd1:    hdr_data = pps_count;
            2'd2:    hdr_data = frame_count ^ pps_count;
            default: hdr_data = frame_count + pps_count;
        endcase
    end

    function automatic logic [31:0] hdr_word(input logic [31:0] fc, input logic [31:0] pps,
                                             input int i);
        case (i)
            0:       return fc;
            1:       return pps;
            2:       return fc ^ pps;
            default: return fc + pps;
        endcase
    endfunction

    // First-word-fall-through sample FIFO model.
    logic [31:0] fifo_mem [0:255];
    int          fifo_wr = 0;
    int          fifo_rd = 0;
    logic        hold_empty = 1'b0;
    assign pay_empty = (fifo_rd == fifo_wr) || hold_empty;
    assign pay_data  = fifo_mem[fifo_rd[7:0]];
    always @(posedge clk) if (pay_rd_en) fifo_rd <= fifo_rd + 1;

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 1; i <= n; i++) begin
            fifo_mem[fifo_wr[7:0]] = base + 32'(i);
            fifo_wr++;
        end
    endtask

    // Upstream FIFO capture and strobe accounting.
    logic [31:0] cap_mem [0:511];
    int          cap_n = 0;
    int          hdr_pulses = 0;
    int          pay_pulses = 0;
    int          coupling_err = 0;
    always @(posedge clk) begin
        if (out_wr_en) begin
            cap_mem[cap_n[8:0]] <= out_data;
            cap_n <= cap_n + 1;
        end
        if (hdr_rd_en) hdr_pulses <= hdr_pulses + 1;
        if (pay_rd_en) pay_pulses <= pay_pulses + 1;
        if ((hdr_rd_en && pay_rd_en) || (out_wr_en != (hdr_rd_en || pay_rd_en)))
            coupling_err <= coupling_err + 1;
    end

    function automatic logic [31:0] cap_at(input int i);
        logic [8:0] idx;
        idx = 9'(i);
        return cap_mem[idx];
    endfunction

    task automatic wait_idle(output bit timed_out);
        int k;
        k = 0;
        while (busy === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        timed_out = (k >= 200);
    endtask

    task automatic pps_pulse();
        pps_in = 1'b1;
        repeat (3) @(negedge clk);
        pps_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({busy, hdr_rd_en, pay_rd_en, out_wr_en} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: busy/hdr/pay/wr=%b required 0000",
                     {busy, hdr_rd_en, pay_rd_en, out_wr_en});
        end
        n_tests++;
        if (out_data !== 32'd0 || frame_count !== 32'd0 || pps_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: out_data=%h fc=%h pps=%h required all 0",
                     out_data, frame_count, pps_count);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_free_run();
        int c0, h0, p0;
        logic [31:0] exp;
        push_words(32'd0, 8);
        c0 = cap_n; h0 = hdr_pulses; p0 = pay_pulses;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (11) @(negedge clk);
        n_tests++;
        if (frame_count !== 32'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL free_run_cycle12: fc=%h busy=%b required 0 and 1", frame_count, busy);
        end
        @(negedge clk);
        n_tests++;
        if (frame_count !== 32'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL free_run_cycle13: fc=%h busy=%b required 1 and 0", frame_count, busy);
        end
        n_tests++;
        if (cap_n - c0 != 12 || hdr_pulses - h0 != 4 || pay_pulses - p0 != 8) begin
            n_fail++;
            $display("FAIL free_run_counts: writes=%0d hdr=%0d pay=%0d required 12 4 8",
                     cap_n - c0, hdr_pulses - h0, pay_pulses - p0);
        end
        for (int i = 0; i < 12; i++) begin
            exp = (i < 4) ? hdr_word(32'd0, 32'd0, i) : 32'(i - 3);
            n_tests++;
            if (cap_at(c0 + i) !== exp) begin
                n_fail++;
                $display("FAIL free_run_word%0d: got %h required %h", i, cap_at(c0 + i), exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int c0, h0, k, stall_err;
        bit to;
        logic [31:0] exp;
        push_words(32'h100, 8);
        c0 = cap_n; h0 = hdr_pulses; stall_err = 0;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 100) begin
            out_full = k[0];
            #1;
            if (out_full && (out_wr_en || hdr_rd_en || pay_rd_en)) stall_err++;
            @(negedge clk);
            k++;
        end
        out_full = 1'b0;
        to = (k >= 100);
        n_tests++;
        if (to || stall_err != 0) begin
            n_fail++;
            $display("FAIL backpressure_stall: timeout=%b strobes_while_full=%0d required 0 0",
                     to, stall_err);
        end
        n_tests++;
        if (cap_n - c0 != 12 || hdr_pulses - h0 != 4 || gen_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL backpressure_counts: writes=%0d hdr=%0d gen=%0d required 12 4 0",
                     cap_n - c0, hdr_pulses - h0, gen_idx);
        end
        for (int i = 0; i < 12; i++) begin
            exp = (i < 4) ? hdr_word(32'd1, 32'd0, i) : 32'h100 + 32'(i - 3);
            n_tests++;
            if (cap_at(c0 + i) !== exp) begin
                n_fail++;
                $display("FAIL backpressure_word%0d: got %h required %h", i, cap_at(c0 + i), exp);
            end
        end
    endtask

    task automatic test_underflow();
        int c0, p0, k, gap_err;
        bit to;
        logic [31:0] exp;
        push_words(32'h200, 3);
        c0 = cap_n; p0 = pay_pulses; gap_err = 0;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        k = 0;
        while (pay_pulses - p0 < 3 && k < 50) begin
            @(negedge clk);
            k++;
        end
        hold_empty = 1'b1;
        push_words(32'h203, 5);
        for (int j = 0; j < 20; j++) begin
            #1;
            if (hdr_rd_en || pay_rd_en || out_wr_en || !busy) gap_err++;
            @(negedge clk);
        end
        n_tests++;
        if (k >= 50 || gap_err != 0) begin
            n_fail++;
            $display("FAIL underflow_gap: timeout=%b bad_cycles=%0d required 0 0", k >= 50, gap_err);
        end
        hold_empty = 1'b0;
        #1;
        n_tests++;
        if (pay_rd_en !== 1'b1 || out_data !== 32'h204) begin
            n_fail++;
            $display("FAIL underflow_resume: pay_rd_en=%b out_data=%h required 1 00000204",
                     pay_rd_en, out_data);
        end
        wait_idle(to);
        n_tests++;
        if (to || frame_count !== 32'd3) begin
            n_fail++;
            $display("FAIL underflow_done: timeout=%b fc=%h required 0 3", to, frame_count);
        end
        for (int i = 0; i < 12; i++) begin
            exp = (i < 4) ? hdr_word(32'd2, 32'd0, i) : 32'h200 + 32'(i - 3);
            n_tests++;
            if (cap_at(c0 + i) !== exp) begin
                n_fail++;
                $display("FAIL underflow_word%0d: got %h required %h", i, cap_at(c0 + i), exp);
            end
        end
    endtask

    task automatic test_pps();
        int c0, c1;
        bit to;
        repeat (3) pps_pulse();
        repeat (4) @(negedge clk);
        n_tests++;
        if (pps_count !== 32'd0) begin
            n_fail++;
            $display("FAIL pps_no_early_snapshot: pps_count=%h required 0", pps_count);
        end
        push_words(32'h300, 8);
        c0 = cap_n;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (2) pps_pulse();
        wait_idle(to);
        repeat (4) @(negedge clk);
        push_words(32'h400, 8);
        c1 = cap_n;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_idle(to);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (cap_at(c0 + i) !== hdr_word(32'd3, 32'd3, i)) begin
                n_fail++;
                $display("FAIL pps_frame0_hdr%0d: got %h required %h", i, cap_at(c0 + i),
                         hdr_word(32'd3, 32'd3, i));
            end
            n_tests++;
            if (cap_at(c1 + i) !== hdr_word(32'd4, 32'd5, i)) begin
                n_fail++;
                $display("FAIL pps_frame1_hdr%0d: got %h required %h", i, cap_at(c1 + i),
                         hdr_word(32'd4, 32'd5, i));
            end
        end
        n_tests++;
        if (to || pps_count !== 32'd5 || frame_count !== 32'd5) begin
            n_fail++;
            $display("FAIL pps_final: timeout=%b pps=%h fc=%h required 0 5 5",
                     to, pps_count, frame_count);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        push_words(32'h700, 16);
        c0 = cap_n;
        enable = 1'b1;
        repeat (13) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || cap_n - c0 != 12) begin
            n_fail++;
            $display("FAIL b2b_gap: busy=%b writes=%0d required 0 12", busy, cap_n - c0);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b required 1", busy);
        end
        repeat (12) @(negedge clk);
        enable = 1'b0;
        n_tests++;
        if (cap_n - c0 != 24 || frame_count !== 32'd7 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_two_frames: writes=%0d fc=%h busy=%b required 24 7 0",
                     cap_n - c0, frame_count, busy);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (cap_at(c0 + 16 + i) !== 32'h709 + 32'(i)) begin
                n_fail++;
                $display("FAIL b2b_frame1_pay%0d: got %h required %h", i, cap_at(c0 + 16 + i),
                         32'h709 + 32'(i));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_enable_drop_and_wrap();
        int c0, p0, k, c_end;
        bit to;
        push_words(32'h600, 8);
        c0 = cap_n; p0 = pay_pulses;
        enable = 1'b1;
        k = 0;
        while (pay_pulses - p0 < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        wait_idle(to);
        c_end = cap_n;
        repeat (5) @(negedge clk);
        n_tests++;
        if (to || k >= 50 || c_end - c0 != 12 || frame_count !== 32'd8) begin
            n_fail++;
            $display("FAIL enable_drop_complete: timeout=%b writes=%0d fc=%h required 0 12 8",
                     to || k >= 50, c_end - c0, frame_count);
        end
        n_tests++;
        if (busy !== 1'b0 || cap_n != c_end) begin
            n_fail++;
            $display("FAIL enable_drop_idle: busy=%b extra_writes=%0d required 0 0",
                     busy, cap_n - c_end);
        end
        force dut.frame_count_q = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        release dut.frame_count_q;
        #1;
        n_tests++;
        if (frame_count !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_preset: fc=%h required ffffffff", frame_count);
        end
        push_words(32'h800, 8);
        c0 = cap_n;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_idle(to);
        n_tests++;
        if (to || cap_at(c0) !== 32'hFFFF_FFFF || frame_count !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap: timeout=%b hdr0=%h fc=%h required 0 ffffffff 0",
                     to, cap_at(c0), frame_count);
        end
    endtask

    task automatic test_reset_mid_pay();
        int c0, p0, k;
        bit to;
        logic [31:0] exp;
        push_words(32'h900, 8);
        p0 = pay_pulses;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        k = 0;
        while (pay_pulses - p0 < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (k >= 50 || {busy, hdr_rd_en, pay_rd_en, out_wr_en} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pay_strobes: timeout=%b busy/hdr/pay/wr=%b required 0 0000",
                     k >= 50, {busy, hdr_rd_en, pay_rd_en, out_wr_en});
        end
        n_tests++;
        if (frame_count !== 32'd0 || pps_count !== 32'd0 || out_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_pay_counters: fc=%h pps=%h out_data=%h required 0 0 0",
                     frame_count, pps_count, out_data);
        end
        repeat (2) @(negedge clk);
        fifo_wr = fifo_rd;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pay_no_resume: busy=%b required 0", busy);
        end
        push_words(32'hA00, 8);
        c0 = cap_n;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_idle(to);
        n_tests++;
        if (to || cap_n - c0 != 12 || frame_count !== 32'd1) begin
            n_fail++;
            $display("FAIL reset_mid_pay_fresh: timeout=%b writes=%0d fc=%h required 0 12 1",
                     to, cap_n - c0, frame_count);
        end
        for (int i = 0; i < 12; i++) begin
            exp = (i < 4) ? hdr_word(32'd0, 32'd0, i) : 32'hA00 + 32'(i - 3);
            n_tests++;
            if (cap_at(c0 + i) !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_pay_word%0d: got %h required %h", i, cap_at(c0 + i), exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_underflow();
        test_pps();
        test_back_to_back();
        test_enable_drop_and_wrap();
        test_reset_mid_pay();
        n_tests++;
        if (coupling_err != 0) begin
            n_fail++;
            $display("FAIL strobe_coupling: violations=%0d required 0", coupling_err);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
